// File: rtl/mem_access_if.sv
// Bundles the mem_access bus signals: upstream instruction record, data memory
// request/response, and the writeback record.
//   slave  : used by mem_access (consumes records, drives memory and writeback)
//   master : used by whatever sits around the stage (producer, memory, consumer)
interface mem_access_if #(
    parameter int unsigned ADDR_W = 32
);
    // Upstream instruction record
    logic              in_valid;
    logic              in_ready;
    logic              is_load;
    logic              is_store;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] alu_result;
    logic [31:0]       store_data;
    logic [4:0]        rd;
    // Data memory
    logic              mem_req;
    logic              mem_ready;
    logic [ADDR_W-3:0] mem_addr;
    logic [3:0]        mem_we;
    logic [31:0]       mem_wdata;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    // Writeback record
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        out_rd;
    logic [31:0]       out_data;
    logic              out_we;
    logic              out_fault;

    modport slave (
        input  in_valid, is_load, is_store, funct3, alu_result, store_data, rd,
        output in_ready,
        output mem_req, mem_addr, mem_we, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output out_valid, out_rd, out_data, out_we, out_fault,
        input  out_ready
    );

    modport master (
        output in_valid, is_load, is_store, funct3, alu_result, store_data, rd,
        input  in_ready,
        input  mem_req, mem_addr, mem_we, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  out_valid, out_rd, out_data, out_we, out_fault,
        output out_ready
    );
endinterface

// File: rtl/mem_access.sv
// Load/store pipeline stage. Accepts one instruction record at a time, performs
// the data memory access for loads/stores (byte enables, lane replication, load
// alignment and extension), and presents one writeback record per instruction.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : mem_access_if.slave (record in, memory request/response, writeback out)
module mem_access #(
    parameter int unsigned ADDR_W = 32
) (
    input logic         clk,
    input logic         rst,
    mem_access_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic              st_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       sdata_q;
    logic [4:0]        rd_q;
    logic [31:0]       out_data_q, out_data_d;
    logic              out_we_q, out_we_d;
    logic              out_fault_q, out_fault_d;

    // Decode of the record currently offered upstream.
    logic       can_accept, accept;
    logic       in_mem, illegal_ld, illegal_st, misalign, in_fault;
    logic [1:0] in_size;

    assign can_accept = (state_q == StIdle) || ((state_q == StResp) && bus.out_ready);
    assign accept     = bus.in_valid && can_accept;

    assign in_size    = bus.funct3[1:0];
    assign in_mem     = bus.is_load || bus.is_store;
    assign illegal_ld = bus.funct3 inside {3'b011, 3'b110, 3'b111};
    assign illegal_st = !(bus.funct3 inside {3'b000, 3'b001, 3'b010});
    assign misalign   = ((in_size == 2'b01) && bus.alu_result[0]) ||
                        ((in_size == 2'b10) && (bus.alu_result[1:0] != 2'b00));
    assign in_fault   = (bus.is_load && bus.is_store) ||
                        (bus.is_load && illegal_ld) ||
                        (bus.is_store && illegal_st) ||
                        (in_mem && misalign);

    // Load alignment: bring the addressed lane down to bit 0, then extend.
    logic [31:0] shifted, load_data;
    assign shifted = bus.mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (f3_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'b0, shifted[7:0]};
            3'b101:  load_data = {16'b0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Store lanes, little-endian.
    logic [3:0]  st_we;
    logic [31:0] st_wdata;

    always_comb begin
        case (f3_q[1:0])
            2'b00: begin
                st_we    = 4'b0001 << addr_q[1:0];
                st_wdata = {4{sdata_q[7:0]}};
            end
            2'b01: begin
                st_we    = 4'b0011 << addr_q[1:0];
                st_wdata = {2{sdata_q[15:0]}};
            end
            default: begin
                st_we    = 4'b1111;
                st_wdata = sdata_q;
            end
        endcase
    end

    // State register and latched record.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            st_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= '0;
            sdata_q     <= 32'h0;
            rd_q        <= 5'd0;
            out_data_q  <= 32'h0;
            out_we_q    <= 1'b0;
            out_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_we_q    <= out_we_d;
            out_fault_q <= out_fault_d;
            if (accept) begin
                st_q    <= bus.is_store;
                f3_q    <= bus.funct3;
                addr_q  <= bus.alu_result;
                sdata_q <= bus.store_data;
                rd_q    <= bus.rd;
            end
        end
    end

    // Next-state logic. An accepted record is resolved immediately for
    // pass-through values and faults; only legal memory ops go to REQ.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_we_d    = out_we_q;
        out_fault_d = out_fault_q;
        if (accept) begin
            if (!in_mem) begin
                state_d     = StResp;
                out_data_d  = 32'(bus.alu_result);
                out_we_d    = (bus.rd != 5'd0);
                out_fault_d = 1'b0;
            end else if (in_fault) begin
                state_d     = StResp;
                out_data_d  = 32'h0;
                out_we_d    = 1'b0;
                out_fault_d = 1'b1;
            end else begin
                state_d     = StReq;
            end
        end else begin
            case (state_q)
                StReq: begin
                    if (bus.mem_ready) begin
                        if (st_q) begin
                            state_d     = StResp;
                            out_data_d  = 32'h0;
                            out_we_d    = 1'b0;
                            out_fault_d = 1'b0;
                        end else begin
                            state_d = StWait;
                        end
                    end
                end
                StWait: begin
                    if (bus.mem_rvalid) begin
                        state_d     = StResp;
                        out_data_d  = load_data;
                        out_we_d    = (rd_q != 5'd0);
                        out_fault_d = 1'b0;
                    end
                end
                StResp: begin
                    if (bus.out_ready) state_d = StIdle;
                end
                default: ;
            endcase
        end
    end

    // Outputs: everything is zero outside the state that owns it.
    always_comb begin
        bus.in_ready  = can_accept;
        bus.mem_req   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_we    = 4'b0000;
        bus.mem_wdata = 32'h0;
        bus.out_valid = 1'b0;
        bus.out_rd    = 5'd0;
        bus.out_data  = 32'h0;
        bus.out_we    = 1'b0;
        bus.out_fault = 1'b0;
        case (state_q)
            StReq: begin
                bus.mem_req   = 1'b1;
                bus.mem_addr  = addr_q[ADDR_W-1:2];
                bus.mem_we    = st_q ? st_we : 4'b0000;
                bus.mem_wdata = st_q ? st_wdata : 32'h0;
            end
            StResp: begin
                bus.out_valid = 1'b1;
                bus.out_rd    = rd_q;
                bus.out_data  = out_data_q;
                bus.out_we    = out_we_q;
                bus.out_fault = out_fault_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_if #(.ADDR_W(32)) bus ();
    mem_access #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [4:0]  rd;
    } instr_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        logic        fault;
        logic        mem;
        logic        load;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model state: at most one instruction in flight.
    bit          busy = 0, req_pend = 0, wait_pend = 0, acc_flag = 0;
    int          ready_at = 0;
    exp_t        cur;
    instr_t      cur_in;
    logic [29:0] rsp_word = '0;
    instr_t      stream[$];
    int          n_random = 0;
    bit          no_rvalid = 0, force_rvalid = 0;
    int          lo_burst = 0;
    localparam int Big = 1 << 30;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Static memory image; word 0x80 (byte 0x200) holds the test-plan pattern.
    function automatic logic [31:0] mem_fn(input logic [29:0] w);
        if (w == 30'h80) return 32'h80FF7F01;
        return {2'b00, w} * 32'h9E3779B9 + 32'h01234567;
    endfunction

    function automatic exp_t model(input instr_t i);
        exp_t        e;
        logic [31:0] word, v;
        int          o, sz;
        bit          bad;
        e = '{default: '0};
        e.rd = i.rd;
        e.addr = i.addr;
        o = int'(i.addr % 4);
        sz = int'(i.f3 % 4);
        if (!i.ld && !i.st) begin
            e.data = i.addr;
            e.we = (i.rd != 0);
            return e;
        end
        if (i.ld && i.st) bad = 1;
        else if (i.ld) bad = !(i.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        else bad = (i.f3 > 3'd2);
        if ((sz == 1 && (i.addr % 2) != 0) || (sz == 2 && o != 0)) bad = 1;
        if (bad) begin
            e.fault = 1;
            return e;
        end
        e.mem = 1;
        e.load = i.ld;
        if (i.ld) begin
            word = mem_fn(i.addr[31:2]);
            v = word >> (8 * o);
            case (i.f3)
                3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v + 32'hFFFFFF00; end
                3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v + 32'hFFFF0000; end
                3'd4: v = v & 32'hFF;
                3'd5: v = v & 32'hFFFF;
                default: v = word;
            endcase
            e.data = v;
            e.we = (i.rd != 0);
        end else begin
            if (sz == 0) begin
                e.be = 4'b0001 << o;
                e.wdata = (i.sd & 32'hFF) * 32'h01010101;
            end else if (sz == 1) begin
                e.be = 4'b0011 << o;
                e.wdata = (i.sd & 32'hFFFF) * 32'h00010001;
            end else begin
                e.be = 4'b1111;
                e.wdata = i.sd;
            end
        end
        return e;
    endfunction

    function automatic instr_t mk(input bit ld, input bit st, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] sd,
                                  input logic [4:0] rd);
        instr_t i;
        i.ld = ld; i.st = st; i.f3 = f3; i.addr = addr; i.sd = sd; i.rd = rd;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        int     k;
        logic [2:0] lf [5];
        lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        k = $urandom_range(0, 9);
        i = mk(0, 0, 3'($urandom), $urandom, $urandom, 5'($urandom));
        if ($urandom_range(0, 7) == 0) i.rd = 5'd0;
        if (k < 3) begin
            // pass-through
        end else if (k < 6) begin
            i.ld = 1;
            if ($urandom_range(0, 7) != 0) i.f3 = lf[$urandom_range(0, 4)];
        end else if (k < 9) begin
            i.st = 1;
            if ($urandom_range(0, 7) != 0) i.f3 = 3'($urandom_range(0, 2));
        end else begin
            i.ld = 1; i.st = 1;
        end
        if ($urandom_range(0, 3) != 0) begin
            if (i.f3[1:0] == 2'b01) i.addr[0] = 1'b0;
            if (i.f3[1:0] == 2'b10) i.addr[1:0] = 2'b00;
        end
        return i;
    endfunction

    // Monitor and compare: sample settled values on the falling edge.
    initial begin
        bit exp_ov, exp_ir;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 0; req_pend = 0; wait_pend = 0;
            end else begin
                exp_ov = busy && (ready_at <= cyc);
                exp_ir = !busy || (exp_ov && bus.out_ready);
                chk("in_ready", 32'(bus.in_ready), 32'(exp_ir));
                chk("mem_req", 32'(bus.mem_req), 32'(req_pend));
                if (req_pend && bus.mem_req) begin
                    chk("mem_addr", 32'(bus.mem_addr), 32'(cur.addr[31:2]));
                    chk("mem_we", 32'(bus.mem_we), 32'(cur.be));
                    chk("mem_wdata", bus.mem_wdata, cur.wdata);
                end
                chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
                if (exp_ov && bus.out_valid) begin
                    chk("out_rd", 32'(bus.out_rd), 32'(cur.rd));
                    chk("out_data", bus.out_data, cur.data);
                    chk("out_we", 32'(bus.out_we), 32'(cur.we));
                    chk("out_fault", 32'(bus.out_fault), 32'(cur.fault));
                end
                if (req_pend && bus.mem_ready) begin
                    req_pend = 0;
                    if (cur.load) begin
                        wait_pend = 1;
                        rsp_word = cur.addr[31:2];
                    end else begin
                        ready_at = cyc + 1;
                    end
                end else if (wait_pend && bus.mem_rvalid) begin
                    wait_pend = 0;
                    ready_at = cyc + 1;
                end
                if (exp_ov && bus.out_ready) busy = 0;
                if (bus.in_valid && exp_ir) begin
                    cur = model(cur_in);
                    busy = 1;
                    acc_flag = 1;
                    if (cur.mem) begin
                        req_pend = 1;
                        ready_at = Big;
                    end else begin
                        ready_at = cyc + 1;
                    end
                end
            end
            cyc++;
        end
    end

    // Upstream producer: holds a record until it is accepted.
    initial begin
        bus.in_valid = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && (acc_flag || !bus.in_valid)) begin
                acc_flag = 0;
                bus.in_valid = 0;
                if (stream.size() > 0) begin
                    cur_in = stream.pop_front();
                    bus.in_valid = 1;
                end else if (n_random > 0 && $urandom_range(0, 3) != 0) begin
                    cur_in = rand_instr();
                    n_random--;
                    bus.in_valid = 1;
                end else begin
                    cur_in = rand_instr();
                end
                bus.is_load    = cur_in.ld;
                bus.is_store   = cur_in.st;
                bus.funct3     = cur_in.f3;
                bus.alu_result = cur_in.addr;
                bus.store_data = cur_in.sd;
                bus.rd         = cur_in.rd;
            end
        end
    end

    // Memory responder.
    initial begin
        bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ready = 1'($urandom_range(0, 1));
            if (force_rvalid) begin
                bus.mem_rvalid = 1;
                bus.mem_rdata = $urandom;
            end else if (no_rvalid) begin
                bus.mem_rvalid = 0;
            end else if (wait_pend) begin
                bus.mem_rvalid = 1'($urandom_range(0, 1));
                bus.mem_rdata = mem_fn(rsp_word);
            end else begin
                // Stray responses outside a pending load must be ignored.
                bus.mem_rvalid = ($urandom_range(0, 9) == 0);
                bus.mem_rdata = $urandom;
            end
        end
    end

    // Writeback consumer with occasional 4-cycle stalls.
    initial begin
        bus.out_ready = 0;
        forever begin
            @(posedge clk);
            #1;
            if (lo_burst > 0) begin
                lo_burst--;
                bus.out_ready = 0;
            end else if ($urandom_range(0, 19) == 0) begin
                lo_burst = 3;
                bus.out_ready = 0;
            end else begin
                bus.out_ready = ($urandom_range(0, 9) < 7);
            end
        end
    end

    task automatic drain(input string name);
        bit done = 0;
        for (int n = 0; n < 20000 && !done; n++) begin
            @(posedge clk);
            #2;
            if (stream.size() == 0 && n_random == 0 && !bus.in_valid && !busy) done = 1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s timeout busy=%0d queued=%0d", name, busy, stream.size());
        end
    endtask

    initial begin
        exp_t e;
        bit   hit;
        rst = 1;
        repeat (3) @(posedge clk);
        #2 rst = 0;

        // Hand-computed values pinning the model.
        e = model(mk(1, 0, 3'd0, 32'h201, 0, 5'd1)); chk("pin_lb1", e.data, 32'h0000007F);
        e = model(mk(1, 0, 3'd0, 32'h202, 0, 5'd1)); chk("pin_lb2", e.data, 32'hFFFFFFFF);
        e = model(mk(1, 0, 3'd4, 32'h203, 0, 5'd1)); chk("pin_lbu3", e.data, 32'h00000080);
        e = model(mk(1, 0, 3'd1, 32'h202, 0, 5'd1)); chk("pin_lh2", e.data, 32'hFFFF80FF);
        e = model(mk(1, 0, 3'd5, 32'h200, 0, 5'd1)); chk("pin_lhu0", e.data, 32'h00007F01);
        e = model(mk(1, 0, 3'd2, 32'h200, 0, 5'd1)); chk("pin_lw", e.data, 32'h80FF7F01);
        e = model(mk(0, 1, 3'd0, 32'h103, 32'h11223344, 5'd0));
        chk("pin_sb_we", 32'(e.be), 32'h8);
        chk("pin_sb_wdata", e.wdata, 32'h44444444);
        e = model(mk(1, 0, 3'd2, 32'h202, 0, 5'd1)); chk("pin_lw_mis", 32'(e.fault), 1);
        e = model(mk(0, 1, 3'd1, 32'h201, 0, 5'd1)); chk("pin_sh_mis", 32'(e.fault), 1);
        e = model(mk(1, 0, 3'd3, 32'h200, 0, 5'd1)); chk("pin_ld_ill", 32'(e.fault), 1);
        e = model(mk(0, 0, 3'd0, 32'h5, 0, 5'd0));   chk("pin_rd0_we", 32'(e.we), 0);

        // Directed records from the test plan, then randomized traffic.
        stream.push_back(mk(0, 0, 3'd0, 32'd5, 0, 5'd3));
        stream.push_back(mk(0, 0, 3'd0, 32'd7, 0, 5'd3));
        stream.push_back(mk(0, 0, 3'd0, 32'd9, 0, 5'd0));
        stream.push_back(mk(0, 1, 3'd0, 32'h103, 32'h11223344, 5'd0));
        stream.push_back(mk(1, 0, 3'd0, 32'h201, 0, 5'd4));
        stream.push_back(mk(1, 0, 3'd0, 32'h202, 0, 5'd4));
        stream.push_back(mk(1, 0, 3'd4, 32'h203, 0, 5'd4));
        stream.push_back(mk(1, 0, 3'd1, 32'h202, 0, 5'd4));
        stream.push_back(mk(1, 0, 3'd5, 32'h200, 0, 5'd4));
        stream.push_back(mk(1, 0, 3'd2, 32'h200, 0, 5'd4));
        stream.push_back(mk(1, 0, 3'd2, 32'h202, 0, 5'd4));
        stream.push_back(mk(0, 1, 3'd1, 32'h201, 32'hABCD, 5'd4));
        stream.push_back(mk(1, 0, 3'd3, 32'h200, 0, 5'd4));
        n_random = 600;
        drain("drain_random");

        // Reset while a load waits for its response, then a late response.
        no_rvalid = 1;
        stream.push_back(mk(1, 0, 3'd2, 32'h200, 0, 5'd5));
        hit = 0;
        for (int n = 0; n < 500 && !hit; n++) begin
            @(posedge clk);
            #2;
            if (wait_pend) hit = 1;
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL reach_wait timeout busy=%0d", busy);
        end
        @(posedge clk);
        #2 rst = 1;
        @(posedge clk);
        #2 rst = 0;
        force_rvalid = 1;
        @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_mem_req", 32'(bus.mem_req), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_rd", 32'(bus.out_rd), 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_we", 32'(bus.out_we), 0);
        chk("rst_out_fault", 32'(bus.out_fault), 0);
        @(posedge clk);
        #2 force_rvalid = 0;
        repeat (6) @(posedge clk);
        #2 no_rvalid = 0;

        n_random = 150;
        drain("drain_final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_access.md
# mem_access

Load/store stage sitting directly downstream of the integer ALU in the core pipeline. Consumes the ALU result: the effective address for loads and stores, or the final value for all other instructions. Drives a handshaked word-addressed data memory with byte enables, aligns and sign/zero-extends load data, and hands one writeback record per instruction to the register-file write stage.

## Interface
- `ADDR_W`, default 32: width of the byte address taken from the ALU result.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: instruction record valid.
- `in_ready` out 1: record accepted when `in_valid && in_ready`.
- `is_load`, `is_store` in 1 each: op class.
- `funct3` in 3: RV32I width/sign code (000 b, 001 h, 010 w, 100 bu, 101 hu).
- `alu_result` in ADDR_W: effective address, or pass-through value.
- `store_data` in 32: rs2 value.
- `rd` in 5: destination register.
- `mem_req` out 1, `mem_ready` in 1: request handshake.
- `mem_addr` out ADDR_W-2: word address, `alu_result[ADDR_W-1:2]`.
- `mem_we` out 4: byte enables (0 for loads).
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rvalid` in 1, `mem_rdata` in 32: load response.
- `out_valid` out 1, `out_ready` in 1: writeback handshake.
- `out_rd` out 5, `out_data` out 32, `out_we` out 1: writeback record.
- `out_fault` out 1: misaligned access or illegal encoding.

## Operation
- FSM states IDLE, REQ, WAIT, RESP. Reset → IDLE; all outputs 0.
- `in_ready` = (IDLE) or (RESP and `out_ready`). Acceptance from RESP is a back-to-back transfer.
- On accept, latch all inputs, then:
  - Neither load nor store → RESP with `out_data`=`alu_result` and `out_we`=(`rd`≠0).
  - Fault → RESP with `out_fault`=1, `out_we`=0, `out_data`=0, and no memory access. Fault conditions:
    - `is_load` and `is_store` both set;
    - illegal funct3 (load: 011/110/111; store: anything other than 000/001/010);
    - halfword with `addr[0]`=1;
    - word with `addr[1:0]`≠0.
  - Otherwise → REQ.
- REQ: `mem_req`=1. `mem_addr`, `mem_we` and `mem_wdata` are held stable until `mem_ready`. On `mem_ready`:
  - store → RESP, `out_we`=0;
  - load → WAIT.
- Store lanes, little-endian, with `o` = `addr[1:0]`:
  - sb: `mem_we`=0001<<o, wdata={4{d[7:0]}}.
  - sh: `mem_we`=0011<<o, wdata={2{d[15:0]}}.
  - sw: `mem_we`=1111, wdata=d.
- WAIT: on `mem_rvalid`, shift rdata right by 8·o, extend per funct3 (b/h sign-extend, bu/hu zero-extend, w unchanged), then → RESP. `out_we`=(`rd`≠0).
- RESP: `out_valid`=1 and the record is held stable until `out_ready`. Then → IDLE, or → newly decided state if a new record is accepted in the same cycle.
- `out_fault` is valid only with `out_valid`. It is per-record, not sticky.
- `mem_rvalid` outside WAIT is ignored. So is `mem_ready` outside REQ.
- Reset mid-operation returns to IDLE at the next edge and drops `mem_req` and `out_valid`. A late `mem_rvalid` is then ignored.

## Timing
- Record accepted at edge T.
- Non-memory or fault: `out_valid` from T+1.
- Store with `mem_ready` high in the first REQ cycle: `mem_req` at T+1, `out_valid` at T+2.
- Load with `mem_ready` at T+1 and `mem_rvalid` at T+2: `out_valid` at T+3.
- `mem_rvalid` is never sampled in the same cycle as the `mem_ready` handshake. Earliest response is the following cycle.
- Each cycle of `mem_ready` low, `mem_rvalid` low, or `out_ready` low adds exactly one cycle.
- Peak throughput is one non-memory instruction per cycle, via RESP→RESP back-to-back.

## Test plan
- Non-memory stream: add results 5, 7 with `rd`=3, `out_ready`=1 every cycle → `out_valid` on consecutive cycles, data 5 then 7, `out_we`=1. With `rd`=0 → `out_we`=0.
- sb: store_data=0x11223344, addr=0x103 → `mem_addr`=0x40, `mem_we`=1000, wdata=0x44444444. `mem_ready` held low 3 cycles → request signals stable throughout; `out_valid` one cycle after `mem_ready`, `out_we`=0.
- Loads from 0x200, `mem_rdata`=0x80FF7F01:
  - lb +1 → 0x0000007F;
  - lb +2 → 0xFFFFFFFF;
  - lbu +3 → 0x00000080;
  - lh +2 → 0xFFFF80FF;
  - lhu +0 → 0x00007F01;
  - lw → 0x80FF7F01.
- Faults: lw at 0x202, sh at 0x201, load funct3=011 → `out_fault`=1, `out_we`=0, `mem_req` never asserted.
- Reset in WAIT, then `mem_rvalid` pulse → no `out_valid`. Outputs are 0 and `in_ready`=1 the cycle after reset.
- Back-pressure: `out_ready` low 4 cycles in RESP → record held unchanged, `in_ready`=0. Second record accepted in the cycle `out_ready` rises.
